count_scanner: RTL

Downstream consumer of the free-running 26-bit counter. Watches one selectable bit of the counter value, turns each 0→1 transition of that bit into a single-cycle step pulse, and advances an LED pattern on every step. Four pattern modes are supported: hold, rotate, bounce and binary count. The block drives the board LEDs directly and shares the counter's clock domain.

---
 rtl/count_scanner_if.sv | 31 +++
 rtl/count_scanner.sv | 105 ++++++++++
 2 files changed

// File: rtl/count_scanner_if.sv
// rtl/count_scanner_if.sv - counter-sample inputs and LED outputs of count_scanner
//
// Purpose: bundles the counter value, tap/mode controls and the LED/step
//          outputs so the scanner and its driver share one connection.
// Ports (signals):
//   data [WIDTH-1:0]  counter value from the free-running counter
//   tap  [4:0]        index of the data bit that paces the pattern
//   mode [1:0]        0 hold, 1 rotate left, 2 bounce, 3 binary count
//   leds [LEDS-1:0]   registered LED pattern
//   step              one-cycle pulse per accepted step
// Modports: master drives data/tap/mode, slave drives leds/step.
interface count_scanner_if #(
  parameter int WIDTH = 26,
  parameter int LEDS  = 8
);
  logic [WIDTH-1:0] data;
  logic [4:0]       tap;
  logic [1:0]       mode;
  logic [LEDS-1:0]  leds;
  logic             step;

  modport master (
    output data, tap, mode,
    input  leds, step
  );

  modport slave (
    input  data, tap, mode,
    output leds, step
  );
endinterface

// File: rtl/count_scanner.sv
// rtl/count_scanner.sv - steps an LED pattern on rising edges of a tapped counter bit
//
// Purpose: watches data[min(tap, WIDTH-1)], turns each 0->1 transition into
//          a single-cycle step, and advances the LED pattern per mode.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  count_scanner_if.slave: data/tap/mode in, leds/step out (registered)
module count_scanner #(
  parameter int WIDTH = 26,
  parameter int LEDS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  count_scanner_if.slave   bus
);

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  localparam logic [4:0] TAP_MAX = 5'(WIDTH - 1);

  logic [4:0]      tap_eff;
  logic            eb;
  logic            tap_chg;
  logic            edge_hit;
  logic            one_hot;
  logic [LEDS-1:0] shl;
  logic [LEDS-1:0] shr;
  logic [LEDS-1:0] rol;

  logic            smp;
  logic [4:0]      last_tap;
  logic [LEDS-1:0] leds_q;
  logic            step_q;
  dir_t            dir;

  assign tap_eff = (bus.tap > TAP_MAX) ? TAP_MAX : bus.tap;
  assign eb      = bus.data[tap_eff];

  // A tap switch compares bits from two different counter positions, so
  // that cycle only reloads smp and never counts as an edge.
  assign tap_chg  = (tap_eff != last_tap);
  assign edge_hit = eb & ~smp & ~tap_chg;

  assign one_hot = (leds_q != '0) && ((leds_q & (leds_q - 1'b1)) == '0);
  assign shl     = {leds_q[LEDS-2:0], 1'b0};
  assign shr     = {1'b0, leds_q[LEDS-1:1]};
  assign rol     = {leds_q[LEDS-2:0], leds_q[LEDS-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q   <= LEDS'(1);
      step_q   <= 1'b0;
      dir      <= LEFT;
      // smp starts high so a tap bit already set at release is not a step.
      smp      <= 1'b1;
      last_tap <= 5'd0;
    end else begin
      smp      <= eb;
      last_tap <= tap_eff;
      step_q   <= edge_hit;
      if (edge_hit) begin
        case (bus.mode)
          2'd0: begin
            leds_q <= leds_q;
          end
          2'd1: begin
            if (!one_hot) begin
              leds_q <= LEDS'(1);
              dir    <= LEFT;
            end else begin
              leds_q <= rol;
            end
          end
          2'd2: begin
            if (!one_hot) begin
              leds_q <= LEDS'(1);
              dir    <= LEFT;
            end else if (dir == LEFT) begin
              leds_q <= shl;
              // Turn around as soon as the top end lights so it shows once.
              if (shl[LEDS-1]) dir <= RIGHT;
            end else begin
              leds_q <= shr;
              if (shr[0]) dir <= LEFT;
            end
          end
          2'd3: begin
            leds_q <= leds_q + 1'b1;
          end
          default: begin
            leds_q <= leds_q;
          end
        endcase
      end
    end
  end

  assign bus.leds = leds_q;
  assign bus.step = step_q;

endmodule
